key_conditioner: RTL and testbench
==================================

KEY_CONDITIONER -- requirements
Module: key_conditioner

Interface
REQ-001 The module SHALL have parameter DEBOUNCE_CYCLES, default 32'd2000000 (20 ms at 100 MHz), the number of consecutive stable synchronized samples required to accept a key level change.
REQ-002 The module SHALL have parameter LONG_CYCLES, default 32'd300000000 (3 s), the number of held cycles after debounced press that marks a long press.
REQ-003 Port clk, input, 1 bit: single clock, all logic on its rising edge.
REQ-004 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 Ports left_key_raw and right_key_raw, input, 1 bit each: asynchronous, bouncing board buttons, 1 = pressed.
REQ-006 Ports left_key and right_key, output, 1 bit each: debounced key level, registered.
REQ-007 Ports left_pulse and right_pulse, output, 1 bit each: one-cycle press strobe, registered.
REQ-008 Ports left_long and right_long, output, 1 bit each: one-cycle long-press strobe, registered.

Function
REQ-009 Each key SHALL be processed by an identical, fully independent channel; the two channels SHALL share no state.
REQ-010 Each raw input SHALL pass through a 2-flop synchronizer; "sync" denotes the second flop output, lagging raw by 2 clock edges.
REQ-011 Each channel SHALL implement FSM states RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT plus a 32-bit stable counter and a 32-bit hold counter.
REQ-012 RELEASED: sync=1 -> PRESS_WAIT with stable counter = 1; otherwise stay.
REQ-013 PRESS_WAIT: sync=0 -> RELEASED, counter cleared; sync=1 and counter = DEBOUNCE_CYCLES-1 -> PRESSED; otherwise increment counter.
REQ-014 PRESSED: sync=0 -> RELEASE_WAIT with stable counter = 1; otherwise stay.
REQ-015 RELEASE_WAIT: sync=1 -> PRESSED, counter cleared, hold counter NOT cleared; sync=0 and counter = DEBOUNCE_CYCLES-1 -> RELEASED; otherwise increment counter.
REQ-016 Key level output SHALL be 1 in PRESSED and RELEASE_WAIT, 0 in RELEASED and PRESS_WAIT.
REQ-017 Key level SHALL rise on the same edge the FSM enters PRESSED from PRESS_WAIT, i.e. exactly DEBOUNCE_CYCLES+2 edges after a clean raw rising edge.
REQ-018 The press pulse SHALL be 1 for exactly the one cycle in which the key level first goes 0->1; no pulse on release or on RELEASE_WAIT->PRESSED return.
REQ-019 The hold counter SHALL clear on PRESS_WAIT->PRESSED and increment each cycle in PRESSED or RELEASE_WAIT, saturating at LONG_CYCLES.
REQ-020 The long pulse SHALL be 1 for exactly one cycle, when the hold counter transitions from LONG_CYCLES-1 to LONG_CYCLES; at most one long pulse per press, none after saturation.
REQ-021 Simultaneous events on both keys SHALL produce their outputs in the same cycle without interaction.
REQ-022 Counter comparisons SHALL be unsigned 32-bit; DEBOUNCE_CYCLES >= 2 and LONG_CYCLES >= 1 are legal ranges; counters SHALL never wrap.

Reset
REQ-023 While reset=1 at a clock edge, all FSMs SHALL go to RELEASED, all counters and synchronizer flops to 0, and every output to 0 on that edge.
REQ-024 Reset asserted mid-press SHALL drop all outputs to 0 on the next edge; a key still held after reset release SHALL require full debounce again and SHALL then produce a fresh press pulse.

Verification (DEBOUNCE_CYCLES=4, LONG_CYCLES=20)
REQ-025 Clean press: left_key_raw 0->1 at edge 0, held 40 cycles -> left_key=1 and left_pulse=1 at edge 6; left_pulse=0 at edge 7; right outputs stay 0.
REQ-026 Bounce: raw high 3 cycles, low 1, then high steady -> no pulse during bounce; exactly one left_pulse, 6 edges after the final rise.
REQ-027 Long press: hold raw 40 cycles -> left_long=1 for one cycle exactly 20 edges after left_key rose; never again before release.
REQ-028 Release glitch: while pressed, raw low for 3 cycles then high -> left_key stays 1, no extra pulse, hold counter continues; raw low 10 cycles -> left_key falls 6 edges after raw fall.
REQ-029 Both keys: raw rise together -> left_pulse and right_pulse both 1 on the same edge 6.
REQ-030 Reset mid-press: reset=1 one cycle while left_key=1, raw held high -> all outputs 0 after that edge; left_pulse reasserted 6 edges after reset deasserts.

Source files
------------

// File: rtl/key_conditioner.sv
// ---------------------------------------------------------------------------
// key_conditioner
//
// Conditions two bouncing board push-buttons (left and right). Each key has
// its own independent channel. A channel synchronises the raw input, then
// debounces it. For each key it produces:
//   - a clean level,
//   - a one-cycle press strobe,
//   - a one-cycle long-press strobe.
//
// Parameters
//   DEBOUNCE_CYCLES : consecutive stable synchronised samples needed to
//                     accept a level change (legal range >= 2)
//   LONG_CYCLES     : held cycles after the debounced press that mark a
//                     long press (legal range >= 1)
//
// Ports
//   clk            : single clock, rising edge
//   reset          : synchronous, active-high
//   left_key_raw   : raw left button, asynchronous, 1 = pressed
//   right_key_raw  : raw right button, asynchronous, 1 = pressed
//   left_key       : debounced left level (registered)
//   right_key      : debounced right level (registered)
//   left_pulse     : one-cycle left press strobe (registered)
//   right_pulse    : one-cycle right press strobe (registered)
//   left_long      : one-cycle left long-press strobe (registered)
//   right_long     : one-cycle right long-press strobe (registered)
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// key_channel
//
// One key: a 2-flop synchroniser, a four-state debounce FSM, a stable
// counter and a hold counter.
//
// Ports
//   clk        : clock
//   reset      : synchronous, active-high
//   key_raw    : raw button input
//   key        : debounced level
//   pulse      : press strobe
//   long_pulse : long-press strobe
// ---------------------------------------------------------------------------
module key_channel #(
    parameter logic [31:0] DEBOUNCE_CYCLES = 32'd2000000,
    parameter logic [31:0] LONG_CYCLES     = 32'd300000000
) (
    input  logic clk,
    input  logic reset,
    input  logic key_raw,
    output logic key,
    output logic pulse,
    output logic long_pulse
);

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    localparam logic [31:0] STABLE_LAST = DEBOUNCE_CYCLES - 32'd1;
    localparam logic [31:0] HOLD_LAST   = LONG_CYCLES - 32'd1;

    state_t      state;
    logic        sync_0;
    logic        sync_1;
    logic [31:0] stable_cnt;
    logic [31:0] hold_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= RELEASED;
            sync_0     <= 1'b0;
            sync_1     <= 1'b0;
            stable_cnt <= 32'd0;
            hold_cnt   <= 32'd0;
            key        <= 1'b0;
            pulse      <= 1'b0;
            long_pulse <= 1'b0;
        end else begin
            sync_0     <= key_raw;
            sync_1     <= sync_0;
            pulse      <= 1'b0;
            long_pulse <= 1'b0;

            // The hold counter runs for the whole time the key level is 1.
            // This includes release-wait glitches. It saturates, so the long
            // strobe can fire at most once per press.
            if ((state == PRESSED) || (state == RELEASE_WAIT)) begin
                if (hold_cnt < LONG_CYCLES) begin
                    hold_cnt <= hold_cnt + 32'd1;
                    if (hold_cnt == HOLD_LAST) begin
                        long_pulse <= 1'b1;
                    end
                end
            end

            case (state)
                RELEASED: begin
                    if (sync_1) begin
                        state      <= PRESS_WAIT;
                        stable_cnt <= 32'd1;
                    end
                end
                PRESS_WAIT: begin
                    if (!sync_1) begin
                        state      <= RELEASED;
                        stable_cnt <= 32'd0;
                    end else if (stable_cnt == STABLE_LAST) begin
                        // Only this transition counts as a fresh press.
                        state      <= PRESSED;
                        stable_cnt <= 32'd0;
                        hold_cnt   <= 32'd0;
                        key        <= 1'b1;
                        pulse      <= 1'b1;
                    end else begin
                        stable_cnt <= stable_cnt + 32'd1;
                    end
                end
                PRESSED: begin
                    if (!sync_1) begin
                        state      <= RELEASE_WAIT;
                        stable_cnt <= 32'd1;
                    end
                end
                RELEASE_WAIT: begin
                    if (sync_1) begin
                        // The glitch is rejected. The hold count is kept.
                        state      <= PRESSED;
                        stable_cnt <= 32'd0;
                    end else if (stable_cnt == STABLE_LAST) begin
                        state      <= RELEASED;
                        stable_cnt <= 32'd0;
                        key        <= 1'b0;
                    end else begin
                        stable_cnt <= stable_cnt + 32'd1;
                    end
                end
                default: begin
                    state      <= RELEASED;
                    stable_cnt <= 32'd0;
                end
            endcase
        end
    end

endmodule

module key_conditioner #(
    parameter logic [31:0] DEBOUNCE_CYCLES = 32'd2000000,
    parameter logic [31:0] LONG_CYCLES     = 32'd300000000
) (
    input  logic clk,
    input  logic reset,
    input  logic left_key_raw,
    input  logic right_key_raw,
    output logic left_key,
    output logic right_key,
    output logic left_pulse,
    output logic right_pulse,
    output logic left_long,
    output logic right_long
);

    key_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .LONG_CYCLES     (LONG_CYCLES)
    ) u_left (
        .clk        (clk),
        .reset      (reset),
        .key_raw    (left_key_raw),
        .key        (left_key),
        .pulse      (left_pulse),
        .long_pulse (left_long)
    );

    key_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .LONG_CYCLES     (LONG_CYCLES)
    ) u_right (
        .clk        (clk),
        .reset      (reset),
        .key_raw    (right_key_raw),
        .key        (right_key),
        .pulse      (right_pulse),
        .long_pulse (right_long)
    );

endmodule

// File: tb/tb_key_conditioner.sv
// ---------------------------------------------------------------------------
// tb_key_conditioner
//
// Checks key_conditioner with DEBOUNCE_CYCLES=4 and LONG_CYCLES=20.
//
// The reference model is written in terms of behaviour, not the FSM:
//   - a key level toggles once the synchronised input has disagreed with it
//     for DEBOUNCE_CYCLES consecutive samples;
//   - the hold count runs while the level is 1.
//
// Every clock edge compares all six outputs against the model. Directed
// steps also check the edge counts for each scenario.
// ---------------------------------------------------------------------------
module tb_key_conditioner;

    localparam int D = 4;
    localparam int L = 20;

    // ---------------- clock / reset / DUT ----------------
    logic clk = 1'b0;
    logic reset;
    logic left_key_raw;
    logic right_key_raw;
    logic left_key, right_key, left_pulse, right_pulse, left_long, right_long;

    always #5 clk = ~clk;

    key_conditioner #(
        .DEBOUNCE_CYCLES (32'd4),
        .LONG_CYCLES     (32'd20)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .left_key_raw  (left_key_raw),
        .right_key_raw (right_key_raw),
        .left_key      (left_key),
        .right_key     (right_key),
        .left_pulse    (left_pulse),
        .right_pulse   (right_pulse),
        .left_long     (left_long),
        .right_long    (right_long)
    );

    int checks = 0;
    int errors = 0;

    // ---------------- reference model (index 0 = left, 1 = right) ----------------
    logic m_pipe0 [2] = '{1'b0, 1'b0};   // raw delayed by one edge
    logic m_pipe1 [2] = '{1'b0, 1'b0};   // raw delayed by two edges
    logic m_key   [2] = '{1'b0, 1'b0};
    logic m_pulse [2] = '{1'b0, 1'b0};
    logic m_long  [2] = '{1'b0, 1'b0};
    int   m_run   [2] = '{0, 0};          // consecutive samples disagreeing with level
    int   m_hold  [2] = '{0, 0};

    task automatic model_step(input logic rst, input logic l, input logic r);
        logic raw [2];
        raw[0] = l;
        raw[1] = r;
        for (int c = 0; c < 2; c++) begin
            if (rst) begin
                m_pipe0[c] = 1'b0; m_pipe1[c] = 1'b0; m_key[c] = 1'b0;
                m_pulse[c] = 1'b0; m_long[c] = 1'b0; m_run[c] = 0; m_hold[c] = 0;
            end else begin
                m_pulse[c] = 1'b0;
                m_long[c]  = 1'b0;
                if (m_key[c] && m_hold[c] < L) begin
                    m_hold[c]++;
                    if (m_hold[c] == L) m_long[c] = 1'b1;
                end
                if (m_pipe1[c] != m_key[c]) begin
                    m_run[c]++;
                    if (m_run[c] == D) begin
                        m_key[c] = m_pipe1[c];
                        m_run[c] = 0;
                        if (m_key[c]) begin
                            m_pulse[c] = 1'b1;
                            m_hold[c]  = 0;
                        end
                    end
                end else begin
                    m_run[c] = 0;
                end
                m_pipe1[c] = m_pipe0[c];
                m_pipe0[c] = raw[c];
            end
        end
    endtask

    // ---------------- checking helpers ----------------
    task automatic check_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one edge, update the model with the inputs seen at that edge,
    // then compare every output 1 time unit later.
    task automatic tick();
        @(posedge clk);
        model_step(reset, left_key_raw, right_key_raw);
        #1;
        check_bit("left_key",    left_key,    m_key[0]);
        check_bit("right_key",   right_key,   m_key[1]);
        check_bit("left_pulse",  left_pulse,  m_pulse[0]);
        check_bit("right_pulse", right_pulse, m_pulse[1]);
        check_bit("left_long",   left_long,   m_long[0]);
        check_bit("right_long",  right_long,  m_long[1]);
    endtask

    // Tick until a condition holds; n = edges taken, or -1 if the bound expires.
    // which: 0 left_pulse, 1 left_key high, 2 left_long, 3 left_key low
    task automatic wait_for(input int which, input int bound, output int n);
        logic hit;
        n = -1;
        for (int i = 1; i <= bound; i++) begin
            tick();
            case (which)
                0:       hit = left_pulse;
                1:       hit = left_key;
                2:       hit = left_long;
                default: hit = !left_key;
            endcase
            if (hit === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int n;
        int cnt;
        int p;

        reset = 1'b1;
        left_key_raw = 1'b0;
        right_key_raw = 1'b0;
        repeat (3) tick();
        check_bit("reset_left_key",  left_key,  1'b0);
        check_bit("reset_left_pulse", left_pulse, 1'b0);
        check_bit("reset_right_key", right_key, 1'b0);
        reset = 1'b0;
        repeat (5) tick();

        // Clean press: level and strobe 6 edges after the raw rise.
        left_key_raw = 1'b1;
        wait_for(0, 20, n);
        check_int("clean_press_edges", n, 6);
        check_bit("clean_press_key", left_key, 1'b1);
        tick();
        check_bit("clean_pulse_drop", left_pulse, 1'b0);
        // Long strobe 20 edges after the level rose.
        wait_for(2, 40, n);
        check_int("long_edges", n, 19);  // one edge was already spent above
        cnt = 0;
        repeat (15) begin
            tick();
            if (left_long) cnt++;
        end
        check_int("long_once", cnt, 0);
        left_key_raw = 1'b0;
        wait_for(3, 20, n);
        check_int("release_edges", n, 6);
        repeat (10) tick();

        // Bounce: high 3, low 1, then steady high.
        cnt = 0;
        left_key_raw = 1'b1;
        repeat (3) begin tick(); if (left_pulse) cnt++; end
        left_key_raw = 1'b0;
        tick(); if (left_pulse) cnt++;
        left_key_raw = 1'b1;
        wait_for(0, 20, n);
        check_int("bounce_no_early_pulse", cnt, 0);
        check_int("bounce_press_edges", n, 6);

        // Release glitch: 3 low samples are rejected; the hold count keeps running.
        repeat (5) tick();
        left_key_raw = 1'b0;
        cnt = 0;
        repeat (3) begin tick(); if (left_pulse) cnt++; end
        left_key_raw = 1'b1;
        repeat (6) begin tick(); if (left_pulse) cnt++; end
        check_bit("glitch_key_held", left_key, 1'b1);
        check_int("glitch_no_pulse", cnt, 0);
        wait_for(2, 30, n);
        check_int("glitch_long_edges", n, 20 - 5 - 3 - 6);
        left_key_raw = 1'b0;
        wait_for(3, 20, n);
        check_int("glitch_release_edges", n, 6);
        repeat (8) tick();

        // Both keys together.
        left_key_raw = 1'b1;
        right_key_raw = 1'b1;
        wait_for(0, 20, n);
        check_int("both_press_edges", n, 6);
        check_bit("both_right_pulse", right_pulse, 1'b1);
        repeat (3) tick();

        // Reset mid-press with raw still held.
        reset = 1'b1;
        tick();
        check_bit("midreset_left_key",   left_key,   1'b0);
        check_bit("midreset_right_key",  right_key,  1'b0);
        check_bit("midreset_left_pulse", left_pulse, 1'b0);
        reset = 1'b0;
        wait_for(0, 20, n);
        check_int("post_reset_press_edges", n, 6);
        check_bit("post_reset_right_pulse", right_pulse, 1'b1);
        left_key_raw = 1'b0;
        right_key_raw = 1'b0;
        repeat (10) tick();

        // Random phases, from short bounce-like runs to long holds.
        for (int ph = 0; ph < 4; ph++) begin
            case (ph)
                0:       p = 3;
                1:       p = 6;
                2:       p = 40;
                default: p = 10;
            endcase
            repeat (250) begin
                if ($urandom_range(0, p - 1) == 0) left_key_raw = ~left_key_raw;
                if ($urandom_range(0, p - 1) == 0) right_key_raw = ~right_key_raw;
                reset = ($urandom_range(0, 199) == 0);
                tick();
            end
        end
        reset = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
